// File: rtl/axi3_write_blaster.sv
// AXI3 write-burst traffic generator: issues back-to-back INCR bursts on AW/W,
// counts B responses and reports the number of cycles a programmed run took.
module axi3_write_blaster #(
    parameter int                        C_AXI_ID_WIDTH    = 1,
    parameter int                        C_AXI_ADDR_WIDTH  = 32,
    parameter int                        C_AXI_DATA_WIDTH  = 32,
    parameter int                        C_MAX_OUTSTANDING = 8,
    parameter logic [C_AXI_ID_WIDTH-1:0] C_ID              = '0
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,

    input  logic                          start_i,
    input  logic [31:0]                   num_bursts_i,
    input  logic [3:0]                    burst_len_i,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   base_addr_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [31:0]                   cycle_count_o,
    output logic                          bresp_err_o,

    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [C_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
    output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [3:0]                    M_AXI_AWLEN,
    output logic [2:0]                    M_AXI_AWSIZE,
    output logic [1:0]                    M_AXI_AWBURST,
    output logic [1:0]                    M_AXI_AWLOCK,
    output logic [3:0]                    M_AXI_AWCACHE,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic [3:0]                    M_AXI_AWQOS,

    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    output logic [C_AXI_ID_WIDTH-1:0]     M_AXI_WID,
    output logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                          M_AXI_WLAST,

    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    input  logic [C_AXI_ID_WIDTH-1:0]     M_AXI_BID,
    input  logic [1:0]                    M_AXI_BRESP
);

    localparam logic [2:0] AXSIZE = 3'($clog2(C_AXI_DATA_WIDTH / 8));

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                        state;
    logic [31:0]                   num_bursts;
    logic [3:0]                    len;
    logic [C_AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [C_AXI_ADDR_WIDTH-1:0]   addr_step;
    logic [31:0]                   aw_cnt;
    logic [31:0]                   w_cnt;
    logic [31:0]                   b_cnt;
    logic [3:0]                    beat;
    logic [31:0]                   data_cnt;

    logic run;
    logic aw_valid;
    logic w_valid;
    logic w_last;
    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic unused_bid;

    assign run = (state == S_RUN);

    // Valids depend only on registered state, so they cannot change while
    // waiting for READY: counters move only on handshakes and B only frees slots.
    assign aw_valid = run && (aw_cnt < num_bursts)
                      && ((aw_cnt - b_cnt) < 32'(C_MAX_OUTSTANDING));
    // W data for burst k may lead its AW because the sink accepts AW on WLAST.
    assign w_valid  = run && (w_cnt < num_bursts)
                      && ({1'b0, w_cnt} < ({1'b0, aw_cnt} + {32'd0, aw_valid}));
    assign w_last   = (beat == len);

    assign aw_hs = aw_valid && M_AXI_AWREADY;
    assign w_hs  = w_valid && M_AXI_WREADY;
    assign b_hs  = run && M_AXI_BVALID;

    assign M_AXI_AWVALID = aw_valid;
    assign M_AXI_AWID    = C_ID;
    assign M_AXI_AWADDR  = awaddr;
    assign M_AXI_AWLEN   = len;
    assign M_AXI_AWSIZE  = AXSIZE;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWLOCK  = 2'b00;
    assign M_AXI_AWCACHE = 4'b0011;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWQOS   = 4'b0000;

    assign M_AXI_WVALID  = w_valid;
    assign M_AXI_WID     = C_ID;
    assign M_AXI_WDATA   = C_AXI_DATA_WIDTH'(data_cnt);
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = w_last;

    assign M_AXI_BREADY  = 1'b1;
    assign unused_bid    = ^M_AXI_BID;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, matching what the hardware does.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state         <= S_IDLE;
            num_bursts    <= '0;
            len           <= '0;
            awaddr        <= '0;
            addr_step     <= '0;
            aw_cnt        <= '0;
            w_cnt         <= '0;
            b_cnt         <= '0;
            beat          <= '0;
            data_cnt      <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            cycle_count_o <= '0;
            bresp_err_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        num_bursts    <= num_bursts_i;
                        len           <= burst_len_i;
                        awaddr        <= base_addr_i;
                        addr_step     <= C_AXI_ADDR_WIDTH'({1'b0, burst_len_i} + 5'd1) << AXSIZE;
                        aw_cnt        <= '0;
                        w_cnt         <= '0;
                        b_cnt         <= '0;
                        beat          <= '0;
                        data_cnt      <= '0;
                        cycle_count_o <= '0;
                        bresp_err_o   <= 1'b0;
                        if (num_bursts_i != 32'd0) begin
                            state  <= S_RUN;
                            busy_o <= 1'b1;
                        end else begin
                            state  <= S_DONE;
                            done_o <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    cycle_count_o <= cycle_count_o + 32'd1;
                    if (aw_hs) begin
                        aw_cnt <= aw_cnt + 32'd1;
                        awaddr <= awaddr + addr_step;
                    end
                    if (w_hs) begin
                        data_cnt <= data_cnt + 32'd1;
                        if (w_last) begin
                            beat  <= '0;
                            w_cnt <= w_cnt + 32'd1;
                        end else begin
                            beat <= beat + 4'd1;
                        end
                    end
                    if (b_hs) begin
                        b_cnt <= b_cnt + 32'd1;
                        if (M_AXI_BRESP != 2'b00) begin
                            bresp_err_o <= 1'b1;
                        end
                        if (b_cnt + 32'd1 == num_bursts) begin
                            state  <= S_DONE;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
